// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    REDIRECT = 1'b1
  } hz_state_t;

  localparam int REG_W  = 5;
  localparam int RCNT_W = 2;

  localparam logic [REG_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Load-use / redirect / memory-wait hazard control for the 5-stage pipeline,
// with a memory-wait watchdog and saturating performance counters.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             ex_jr,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             ctr_clr,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             flush,
  output logic             ifid_flush,
  output logic             stall_all,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0]   WC_MAX    = WC_W'(MEM_TIMEOUT);
  localparam logic [WC_W-1:0]   WC_LAST   = WC_W'(MEM_TIMEOUT - 1);
  localparam logic [RCNT_W-1:0] RCNT_INIT = RCNT_W'(FLUSH_CYCLES - 1);

  hz_state_t         state, state_next;
  logic [RCNT_W-1:0] rcnt, rcnt_next;
  logic [WC_W-1:0]   wcnt;
  logic              load_use;
  logic              mwait;
  logic              redirect_fire;
  logic              stall_inc;

  assign load_use = ex_mem_read && (ex_rt != ZERO_REG) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign mwait    = mem_req && !mem_ready;

  // A memory wait freezes everything, so EX events seen during it are simply
  // re-evaluated once the wait drops rather than being latched here.
  always_comb begin
    pc_write      = 1'b1;
    ifid_write    = 1'b1;
    flush         = 1'b0;
    ifid_flush    = 1'b0;
    stall_all     = 1'b0;
    state_next    = state;
    rcnt_next     = rcnt;
    redirect_fire = 1'b0;

    if (reset) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      flush      = 1'b1;
      ifid_flush = 1'b1;
    end else if (mwait) begin
      stall_all  = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (state == REDIRECT) begin
      flush      = 1'b1;
      ifid_flush = 1'b1;
      rcnt_next  = (rcnt == '0) ? '0 : rcnt - 1'b1;
      if (rcnt <= RCNT_W'(1)) begin
        state_next = RUN;
      end
    end else if (ex_branch_taken || ex_jr) begin
      flush         = 1'b1;
      ifid_flush    = 1'b1;
      redirect_fire = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_next = REDIRECT;
        rcnt_next  = RCNT_INIT;
      end
    end else if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      flush      = 1'b1;
    end
  end

  // The watchdog flag is sticky until reset; wcnt stops at MEM_TIMEOUT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      rcnt        <= '0;
      wcnt        <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_next;
      rcnt  <= rcnt_next;
      if (mwait) begin
        if (wcnt != WC_MAX) begin
          wcnt <= wcnt + 1'b1;
        end
        if (wcnt == WC_LAST) begin
          mem_timeout <= 1'b1;
        end
      end else begin
        wcnt <= '0;
      end
    end
  end

  assign stall_inc = !pc_write && !reset;

  sat_counter #(.W(CNT_W)) u_stall_ctr (
    .clk   (clk),
    .reset (reset),
    .clr   (ctr_clr),
    .inc   (stall_inc),
    .q     (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_ctr (
    .clk   (clk),
    .reset (reset),
    .clr   (ctr_clr),
    .inc   (redirect_fire),
    .q     (flush_events)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: vector table for single-cycle control
// decisions plus hand-written multi-cycle sequences.
module tb_hazard_controller;

  localparam int FLUSH_CYCLES = 2;
  localparam int MEM_TIMEOUT  = 4;
  localparam int CNT_W        = 2;

  // Control outputs packed as {pc_write, ifid_write, flush, ifid_flush, stall_all}
  localparam logic [4:0] CTL_RUN   = 5'b11000;
  localparam logic [4:0] CTL_LU    = 5'b00100;
  localparam logic [4:0] CTL_REDIR = 5'b11110;
  localparam logic [4:0] CTL_WAIT  = 5'b00001;
  localparam logic [4:0] CTL_RST   = 5'b00110;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic [4:0] e_rt;
    logic       mr;
    logic       br;
    logic       jr;
    logic       req;
    logic       rdy;
    logic [4:0] exp_ctl;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       id_rs, id_rt, ex_rt;
  logic             id_uses_rt, ex_mem_read, ex_branch_taken, ex_jr;
  logic             mem_req, mem_ready, ctr_clr;
  logic             pc_write, ifid_write, flush, ifid_flush, stall_all, mem_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_events;

  int   n_vec = 0;
  int   n_mis = 0;
  vec_t vecs[12];

  always #5 clk = ~clk;

  hazard_controller #(
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .MEM_TIMEOUT  (MEM_TIMEOUT),
    .CNT_W        (CNT_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .ex_rt           (ex_rt),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .ex_jr           (ex_jr),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .ctr_clr         (ctr_clr),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .flush           (flush),
    .ifid_flush      (ifid_flush),
    .stall_all       (stall_all),
    .mem_timeout     (mem_timeout),
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events)
  );

  function automatic vec_t mk_vec(input logic [4:0] rs, rt, input logic uses_rt,
                                  input logic [4:0] e_rt, input logic mr, br, jr, req, rdy,
                                  input logic [4:0] exp_ctl);
    vec_t v;
    v.rs = rs; v.rt = rt; v.uses_rt = uses_rt; v.e_rt = e_rt;
    v.mr = mr; v.br = br; v.jr = jr; v.req = req; v.rdy = rdy;
    v.exp_ctl = exp_ctl;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkCtl(input string name, input logic [4:0] exp);
    checkOutput(name, {11'd0, pc_write, ifid_write, flush, ifid_flush, stall_all}, {11'd0, exp});
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic applyStimulus(input logic [4:0] rs, rt, input logic uses_rt,
                               input logic [4:0] e_rt, input logic mr, br, jr, req, rdy, clr);
    @(negedge clk);
    id_rs = rs; id_rt = rt; id_uses_rt = uses_rt; ex_rt = e_rt;
    ex_mem_read = mr; ex_branch_taken = br; ex_jr = jr;
    mem_req = req; mem_ready = rdy; ctr_clr = clr;
    #1;
  endtask

  task automatic idle(input logic clr);
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, clr);
  endtask

  task automatic load_use_cycle(input logic clr);
    applyStimulus(5'd8, 5'd1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, clr);
  endtask

  task automatic branch_cycle();
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_cycle();
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    vecs[0]  = mk_vec(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CTL_RUN);
    vecs[1]  = mk_vec(5'd8, 5'd2, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CTL_LU);
    vecs[2]  = mk_vec(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CTL_RUN);
    vecs[3]  = mk_vec(5'd4, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CTL_LU);
    vecs[4]  = mk_vec(5'd4, 5'd9, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CTL_RUN);
    vecs[5]  = mk_vec(5'd9, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CTL_RUN);
    vecs[6]  = mk_vec(5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, CTL_RUN);
    vecs[7]  = mk_vec(5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, CTL_WAIT);
    vecs[8]  = mk_vec(5'd8, 5'd2, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, CTL_WAIT);
    vecs[9]  = mk_vec(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, CTL_WAIT);
    vecs[10] = mk_vec(5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CTL_RUN);
    vecs[11] = mk_vec(5'd31, 5'd31, 1'b1, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, CTL_LU);

    reset = 1'b1;
    id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_rt = '0;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0; ex_jr = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; ctr_clr = 1'b0;
    #2;
    checkCtl("reset_ctl", CTL_RST);
    checkOutput("reset_mem_timeout", {15'd0, mem_timeout}, 16'd0);
    checkOutput("reset_counters", {12'd0, stall_cycles, flush_events}, 16'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].rs, vecs[i].rt, vecs[i].uses_rt, vecs[i].e_rt,
                    vecs[i].mr, vecs[i].br, vecs[i].jr, vecs[i].req, vecs[i].rdy, 1'b0);
      checkCtl($sformatf("vec%0d_ctl", i), vecs[i].exp_ctl);
    end

    // Load-use: exactly one bubble, and register 0 never stalls
    idle(1'b1);
    load_use_cycle(1'b0);
    checkCtl("lu_bubble", CTL_LU);
    idle(1'b0);
    checkCtl("lu_after", CTL_RUN);
    checkOutput("lu_stall_cycles", {14'd0, stall_cycles}, 16'd1);
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkCtl("lu_r0", CTL_RUN);
    idle(1'b0);
    checkOutput("lu_r0_stall_cycles", {14'd0, stall_cycles}, 16'd1);

    // Two-cycle redirect; a branch seen during REDIRECT is squashed
    idle(1'b1);
    branch_cycle();
    checkCtl("br_cycle1", CTL_REDIR);
    branch_cycle();
    checkCtl("br_cycle2", CTL_REDIR);
    idle(1'b0);
    checkCtl("br_back_run", CTL_RUN);
    checkOutput("br_flush_events", {14'd0, flush_events}, 16'd1);

    // Memory wait interleaved in a redirect
    idle(1'b1);
    branch_cycle();
    checkCtl("rw_cycle1", CTL_REDIR);
    for (int i = 0; i < 3; i++) begin
      wait_cycle();
      checkCtl($sformatf("rw_wait%0d", i), CTL_WAIT);
    end
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkCtl("rw_resume", CTL_REDIR);
    idle(1'b0);
    checkCtl("rw_done", CTL_RUN);
    checkOutput("rw_flush_events", {14'd0, flush_events}, 16'd1);
    checkOutput("rw_stall_cycles", {14'd0, stall_cycles}, 16'd3);
    checkOutput("rw_no_timeout", {15'd0, mem_timeout}, 16'd0);

    // Load-use and JR together: redirect wins, no stall counted
    idle(1'b1);
    applyStimulus(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkCtl("jr_lu", CTL_REDIR);
    idle(1'b0);
    checkCtl("jr_lu_redirect2", CTL_REDIR);
    idle(1'b0);
    checkCtl("jr_lu_run", CTL_RUN);
    checkOutput("jr_lu_stall_cycles", {14'd0, stall_cycles}, 16'd0);
    checkOutput("jr_lu_flush_events", {14'd0, flush_events}, 16'd1);

    // Counter saturation and clear priority
    idle(1'b1);
    for (int i = 0; i < 5; i++) load_use_cycle(1'b0);
    idle(1'b0);
    checkOutput("sat_stall_cycles", {14'd0, stall_cycles}, 16'd3);
    load_use_cycle(1'b1);
    idle(1'b0);
    checkOutput("clr_over_inc", {14'd0, stall_cycles}, 16'd0);
    for (int i = 0; i < 4; i++) begin
      branch_cycle();
      idle(1'b0);
    end
    idle(1'b0);
    checkOutput("sat_flush_events", {14'd0, flush_events}, 16'd3);

    // Watchdog: sticky after MEM_TIMEOUT consecutive waits
    idle(1'b1);
    for (int i = 1; i <= 5; i++) begin
      wait_cycle();
      checkCtl($sformatf("wd_wait%0d", i), CTL_WAIT);
      if (i == 4) checkOutput("wd_before_edge4", {15'd0, mem_timeout}, 16'd0);
      if (i == 5) checkOutput("wd_after_edge4", {15'd0, mem_timeout}, 16'd1);
    end
    idle(1'b0);
    idle(1'b0);
    checkCtl("wd_run", CTL_RUN);
    checkOutput("wd_sticky", {15'd0, mem_timeout}, 16'd1);
    checkOutput("wd_stall_cycles", {14'd0, stall_cycles}, 16'd3);

    // Reset in the middle of a redirect
    branch_cycle();
    checkCtl("rst_br", CTL_REDIR);
    idle(1'b0);
    reset = 1'b1;
    #1;
    checkCtl("rst_mid_redirect", CTL_RST);
    checkOutput("rst_mem_timeout", {15'd0, mem_timeout}, 16'd0);
    checkOutput("rst_counters", {12'd0, stall_cycles, flush_events}, 16'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkCtl("rst_release_run", CTL_RUN);
    idle(1'b0);
    checkCtl("rst_after_run", CTL_RUN);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
